// File: rtl/ctrl_pipe_if.sv
// Bundle between the ID decoder / EX datapath and the pipeline control unit.
// master drives the decoded ID word and the ALU zero flag;
// slave (ctrl_pipe) returns the staged controls and the hazard/forward selects.
interface ctrl_pipe_if;
    // decoded ID-stage control word
    logic [1:0] id_aluop;
    logic       id_alusrc;
    logic       id_memread;
    logic       id_memwrite;
    logic       id_memtoreg;
    logic       id_regwrite;
    logic       id_regdst;
    logic       id_branch;
    logic       id_branchne;
    logic       id_jump;
    logic       id_jumpr;
    logic       id_link;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       ex_zero;

    // ID/EX stage
    logic [1:0] ex_aluop;
    logic       ex_alusrc;
    logic       ex_branch;
    logic       ex_branchne;
    logic       ex_jump;
    logic       ex_jumpr;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_dst;

    // EX/MEM stage
    logic       mem_memread;
    logic       mem_memwrite;
    logic       mem_memtoreg;
    logic       mem_regwrite;
    logic       mem_link;
    logic [4:0] mem_dst;

    // MEM/WB stage
    logic       wb_memtoreg;
    logic       wb_regwrite;
    logic       wb_link;
    logic [4:0] wb_dst;

    // hazard and forwarding
    logic       pc_stall;
    logic       ifid_flush;
    logic       redirect;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output id_aluop, id_alusrc, id_memread, id_memwrite, id_memtoreg,
               id_regwrite, id_regdst, id_branch, id_branchne, id_jump,
               id_jumpr, id_link, id_rs, id_rt, id_rd, ex_zero,
        input  ex_aluop, ex_alusrc, ex_branch, ex_branchne, ex_jump, ex_jumpr,
               ex_rs, ex_rt, ex_dst,
               mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_link,
               mem_dst,
               wb_memtoreg, wb_regwrite, wb_link, wb_dst,
               pc_stall, ifid_flush, redirect, fwd_a, fwd_b
    );

    modport slave (
        input  id_aluop, id_alusrc, id_memread, id_memwrite, id_memtoreg,
               id_regwrite, id_regdst, id_branch, id_branchne, id_jump,
               id_jumpr, id_link, id_rs, id_rt, id_rd, ex_zero,
        output ex_aluop, ex_alusrc, ex_branch, ex_branchne, ex_jump, ex_jumpr,
               ex_rs, ex_rt, ex_dst,
               mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_link,
               mem_dst,
               wb_memtoreg, wb_regwrite, wb_link, wb_dst,
               pc_stall, ifid_flush, redirect, fwd_a, fwd_b
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipeline control carrier and hazard unit for the 5-stage MIPS core.
// Carries decoded controls through ID/EX, EX/MEM, MEM/WB and produces
// load-use stall, branch/jump redirect + IF/ID flush and EX forwarding selects.
module ctrl_pipe (
    input  logic         clk,
    input  logic         rst,
    ctrl_pipe_if.slave   bus
);
    localparam logic [4:0] LINK_REG = 5'd31;
    localparam int         NSRC     = 2;   // EX operands: 0 = rs (A), 1 = rt (B)

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       branch;
        logic       branchne;
        logic       jump;
        logic       jumpr;
        logic       link;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } idex_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       link;
        logic [4:0] dst;
    } exmem_t;

    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic       link;
        logic [4:0] dst;
    } memwb_t;

    idex_t  id_word;
    idex_t  idex_d, idex_q;
    exmem_t exmem_q;
    memwb_t memwb_q;

    logic   lu;
    logic   redir;

    // Pack the ID inputs and resolve the write destination (link beats regdst)
    always_comb begin
        id_word          = '0;
        id_word.aluop    = bus.id_aluop;
        id_word.alusrc   = bus.id_alusrc;
        id_word.memread  = bus.id_memread;
        id_word.memwrite = bus.id_memwrite;
        id_word.memtoreg = bus.id_memtoreg;
        id_word.regwrite = bus.id_regwrite;
        id_word.branch   = bus.id_branch;
        id_word.branchne = bus.id_branchne;
        id_word.jump     = bus.id_jump;
        id_word.jumpr    = bus.id_jumpr;
        id_word.link     = bus.id_link;
        id_word.rs       = bus.id_rs;
        id_word.rt       = bus.id_rt;
        if (bus.id_link)
            id_word.dst = LINK_REG;
        else if (bus.id_regdst)
            id_word.dst = bus.id_rd;
        else
            id_word.dst = bus.id_rt;
    end

    // Hazards: redirect from EX branch/jump, conservative load-use on rs/rt
    always_comb begin
        redir = idex_q.jump | (idex_q.branch & (bus.ex_zero ^ idex_q.branchne));
        lu    = idex_q.memread & (idex_q.dst != 5'd0) &
                ((idex_q.dst == bus.id_rs) | (idex_q.dst == bus.id_rt));
        // A redirect or a load-use both inject a bubble into EX
        idex_d = (redir | lu) ? idex_t'('0) : id_word;
    end

    // Stage registers; EX/MEM and MEM/WB always advance, reset clears to bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q           <= idex_d;
            exmem_q.memread  <= idex_q.memread;
            exmem_q.memwrite <= idex_q.memwrite;
            exmem_q.memtoreg <= idex_q.memtoreg;
            exmem_q.regwrite <= idex_q.regwrite;
            exmem_q.link     <= idex_q.link;
            exmem_q.dst      <= idex_q.dst;
            memwb_q.memtoreg <= exmem_q.memtoreg;
            memwb_q.regwrite <= exmem_q.regwrite;
            memwb_q.link     <= exmem_q.link;
            memwb_q.dst      <= exmem_q.dst;
        end
    end

    // Forwarding: one select per EX source operand, MEM (newer) beats WB,
    // and $0 never forwards.
    logic [NSRC-1:0][4:0] ex_src;
    logic [NSRC-1:0][1:0] fwd;

    assign ex_src = {idex_q.rt, idex_q.rs};

    for (genvar g = 0; g < NSRC; g++) begin : g_fwd
        logic mem_hit, wb_hit;
        // Compare the operand against the MEM and WB destinations
        always_comb begin
            mem_hit = exmem_q.regwrite & (exmem_q.dst != 5'd0) &
                      (exmem_q.dst == ex_src[g]);
            wb_hit  = memwb_q.regwrite & (memwb_q.dst != 5'd0) &
                      (memwb_q.dst == ex_src[g]);
            if (mem_hit)
                fwd[g] = FWD_MEM;
            else if (wb_hit)
                fwd[g] = FWD_WB;
            else
                fwd[g] = FWD_RF;
        end
    end

    assign bus.ex_aluop     = idex_q.aluop;
    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_branch    = idex_q.branch;
    assign bus.ex_branchne  = idex_q.branchne;
    assign bus.ex_jump      = idex_q.jump;
    assign bus.ex_jumpr     = idex_q.jumpr;
    assign bus.ex_rs        = idex_q.rs;
    assign bus.ex_rt        = idex_q.rt;
    assign bus.ex_dst       = idex_q.dst;

    assign bus.mem_memread  = exmem_q.memread;
    assign bus.mem_memwrite = exmem_q.memwrite;
    assign bus.mem_memtoreg = exmem_q.memtoreg;
    assign bus.mem_regwrite = exmem_q.regwrite;
    assign bus.mem_link     = exmem_q.link;
    assign bus.mem_dst      = exmem_q.dst;

    assign bus.wb_memtoreg  = memwb_q.memtoreg;
    assign bus.wb_regwrite  = memwb_q.regwrite;
    assign bus.wb_link      = memwb_q.link;
    assign bus.wb_dst       = memwb_q.dst;

    // Redirect wins over a (illegal) simultaneous load-use
    assign bus.pc_stall     = lu & ~redir;
    assign bus.ifid_flush   = redir;
    assign bus.redirect     = redir;
    assign bus.fwd_a        = fwd[0];
    assign bus.fwd_b        = fwd[1];
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: an instruction-level pipeline model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_ctrl_pipe;
    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc, memread, memwrite, memtoreg, regwrite, regdst;
        logic       branch, branchne, jump, jumpr, link;
        logic [4:0] rs, rt, rd;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ex_zero = 1'b0;
    ins_t id_i = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctrl_pipe_if bus ();

    assign bus.id_aluop    = id_i.aluop;
    assign bus.id_alusrc   = id_i.alusrc;
    assign bus.id_memread  = id_i.memread;
    assign bus.id_memwrite = id_i.memwrite;
    assign bus.id_memtoreg = id_i.memtoreg;
    assign bus.id_regwrite = id_i.regwrite;
    assign bus.id_regdst   = id_i.regdst;
    assign bus.id_branch   = id_i.branch;
    assign bus.id_branchne = id_i.branchne;
    assign bus.id_jump     = id_i.jump;
    assign bus.id_jumpr    = id_i.jumpr;
    assign bus.id_link     = id_i.link;
    assign bus.id_rs       = id_i.rs;
    assign bus.id_rt       = id_i.rt;
    assign bus.id_rd       = id_i.rd;
    assign bus.ex_zero     = ex_zero;

    ctrl_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    // ---------------- instruction builders ----------------
    function automatic ins_t mk_r(input logic [4:0] rd, rs, rt);
        ins_t i = '0;
        i.aluop = 2'b10; i.regwrite = 1'b1; i.regdst = 1'b1;
        i.rd = rd; i.rs = rs; i.rt = rt;
        return i;
    endfunction
    function automatic ins_t mk_lw(input logic [4:0] rt, rs);
        ins_t i = '0;
        i.alusrc = 1'b1; i.memread = 1'b1; i.memtoreg = 1'b1; i.regwrite = 1'b1;
        i.rt = rt; i.rs = rs;
        return i;
    endfunction
    function automatic ins_t mk_br(input logic [4:0] rs, rt, input logic ne);
        ins_t i = '0;
        i.aluop = 2'b01; i.branch = 1'b1; i.branchne = ne; i.rs = rs; i.rt = rt;
        return i;
    endfunction
    function automatic ins_t mk_jal();
        ins_t i = '0;
        i.jump = 1'b1; i.link = 1'b1; i.regwrite = 1'b1;
        return i;
    endfunction
    function automatic ins_t mk_jr(input logic [4:0] rs);
        ins_t i = '0;
        i.jump = 1'b1; i.jumpr = 1'b1; i.rs = rs;
        return i;
    endfunction

    // ---------------- behavioural model ----------------
    // Which register an instruction writes (0 for a bubble).
    function automatic logic [4:0] dst_of(input ins_t i);
        if (i.link) return 5'd31;
        return i.regdst ? i.rd : i.rt;
    endfunction
    function automatic logic takes_redirect(input ins_t i, input logic z);
        if (i.jump) return 1'b1;
        if (i.branch) return i.branchne ? !z : z;
        return 1'b0;
    endfunction
    function automatic logic load_use(input ins_t e, input ins_t d);
        return e.memread && dst_of(e) != 0 && (dst_of(e) == d.rs || dst_of(e) == d.rt);
    endfunction
    function automatic logic [1:0] fwd_of(input logic [4:0] src, input ins_t m, input ins_t w);
        if (m.regwrite && dst_of(m) != 0 && dst_of(m) == src) return 2'b10;
        if (w.regwrite && dst_of(w) != 0 && dst_of(w) == src) return 2'b01;
        return 2'b00;
    endfunction

    ins_t m_ex = '0, m_mem = '0, m_wb = '0;
    logic started = 1'b0;

    // Advance the model's instructions one stage per clock
    always @(posedge clk) begin
        if (rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            started = 1'b1;
        end else begin
            logic kill;
            kill  = takes_redirect(m_ex, ex_zero) || load_use(m_ex, id_i);
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = kill ? ins_t'('0) : id_i;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        if (started) begin
            logic red, lu;
            red = takes_redirect(m_ex, ex_zero);
            lu  = load_use(m_ex, id_i);
            chk("model_ex",
                {10'd0, bus.ex_aluop, bus.ex_alusrc, bus.ex_branch, bus.ex_branchne,
                 bus.ex_jump, bus.ex_jumpr, bus.ex_rs, bus.ex_rt, bus.ex_dst},
                {10'd0, m_ex.aluop, m_ex.alusrc, m_ex.branch, m_ex.branchne,
                 m_ex.jump, m_ex.jumpr, m_ex.rs, m_ex.rt, dst_of(m_ex)});
            chk("model_mem",
                {22'd0, bus.mem_memread, bus.mem_memwrite, bus.mem_memtoreg,
                 bus.mem_regwrite, bus.mem_link, bus.mem_dst},
                {22'd0, m_mem.memread, m_mem.memwrite, m_mem.memtoreg,
                 m_mem.regwrite, m_mem.link, dst_of(m_mem)});
            chk("model_wb",
                {23'd0, bus.wb_memtoreg, bus.wb_regwrite, bus.wb_link, bus.wb_dst},
                {23'd0, m_wb.memtoreg, m_wb.regwrite, m_wb.link, dst_of(m_wb)});
            chk("model_hazard", {29'd0, bus.pc_stall, bus.ifid_flush, bus.redirect},
                {29'd0, lu && !red, red, red});
            chk("model_fwd", {28'd0, bus.fwd_a, bus.fwd_b},
                {28'd0, fwd_of(m_ex.rs, m_mem, m_wb), fwd_of(m_ex.rt, m_mem, m_wb)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input ins_t i, input logic z);
        id_i = i; ex_zero = z;
        #2;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drain();
        for (int k = 0; k < 4; k++) begin
            put('0, 1'b0);
            tick();
        end
    endtask

    initial begin
        ins_t r;
        logic [31:0] rnd;
        int stalls;

        // reset with random ID inputs, memread forced on
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rnd = $urandom();
            r = rnd[27:0]; r.memread = 1'b1;
            put(r, rnd[31]);
            tick();
        end
        rst = 1'b0;
        rnd = $urandom();
        r = rnd[27:0]; r.memread = 1'b1; r.rs = 5'd0; r.rt = 5'd0;
        put(r, 1'b1);
        chk("rst_ex", {bus.ex_aluop, bus.ex_alusrc, bus.ex_branch, bus.ex_jump,
                       bus.ex_rs, bus.ex_rt, bus.ex_dst}, 0);
        chk("rst_memwb", {bus.mem_memread, bus.mem_regwrite, bus.mem_dst,
                          bus.wb_regwrite, bus.wb_link, bus.wb_dst}, 0);
        chk("rst_hazard", {bus.pc_stall, bus.redirect, bus.fwd_a, bus.fwd_b}, 0);
        drain();

        // pipeline flow of lw $5
        put(mk_lw(5'd5, 5'd1), 1'b0); tick();
        put('0, 1'b0);
        chk("flow_ex_dst", bus.ex_dst, 5);
        tick(); put('0, 1'b0);
        chk("flow_mem", {bus.mem_memread, bus.mem_dst}, {1'b1, 5'd5});
        tick(); put('0, 1'b0);
        chk("flow_wb", {bus.wb_memtoreg, bus.wb_dst}, {1'b1, 5'd5});
        drain();

        // load-use: lw $5 then add $6,$5,$7
        put(mk_lw(5'd5, 5'd2), 1'b0); tick();
        put(mk_r(5'd6, 5'd5, 5'd7), 1'b0);
        chk("lu_stall", bus.pc_stall, 1);
        tick();
        put(mk_r(5'd6, 5'd5, 5'd7), 1'b0);
        chk("lu_bubble", {bus.pc_stall, bus.ex_rs, bus.ex_dst, bus.mem_memread},
            {1'b0, 5'd0, 5'd0, 1'b1});
        tick(); put('0, 1'b0);
        chk("lu_fwd", {bus.ex_rs, bus.ex_dst, bus.fwd_a}, {5'd5, 5'd6, 2'b01});
        drain();

        // forwarding priority: MEM over WB
        put(mk_r(5'd3, 5'd1, 5'd2), 1'b0); tick();
        put(mk_r(5'd3, 5'd4, 5'd5), 1'b0); tick();
        put(mk_r(5'd8, 5'd3, 5'd3), 1'b0); tick();
        put('0, 1'b0);
        chk("fwd_mem_pri", {bus.fwd_a, bus.fwd_b}, {2'b10, 2'b10});
        drain();
        // MEM writes $0, WB writes $3
        put(mk_r(5'd3, 5'd1, 5'd2), 1'b0); tick();
        put(mk_r(5'd0, 5'd1, 5'd2), 1'b0); tick();
        put(mk_r(5'd9, 5'd3, 5'd4), 1'b0); tick();
        put('0, 1'b0);
        chk("fwd_wb", {bus.fwd_a, bus.fwd_b}, {2'b01, 2'b00});
        // EX sources $0 while MEM writes $0
        put(mk_r(5'd0, 5'd1, 5'd2), 1'b0); tick();
        put(mk_r(5'd10, 5'd0, 5'd0), 1'b0); tick();
        put('0, 1'b0);
        chk("fwd_zero", {bus.fwd_a, bus.fwd_b}, 0);
        drain();

        // taken beq flushes the following instruction
        put(mk_br(5'd1, 5'd2, 1'b0), 1'b0); tick();
        put(mk_r(5'd11, 5'd1, 5'd1), 1'b1);
        chk("beq_redirect", {bus.redirect, bus.ifid_flush, bus.pc_stall}, 3'b110);
        tick(); put('0, 1'b0);
        chk("beq_bubble", {bus.ex_rs, bus.ex_dst, bus.ex_branch}, 0);
        drain();

        // bne with zero set is not taken, zero clear is taken
        put(mk_br(5'd1, 5'd2, 1'b1), 1'b0); tick();
        put('0, 1'b1);
        chk("bne_not_taken", bus.redirect, 0);
        ex_zero = 1'b0; #1;
        chk("bne_taken", bus.redirect, 1);
        tick(); drain();

        // jal carries link to WB with dst 31
        put(mk_jal(), 1'b0); tick();
        put('0, 1'b0);
        chk("jal_redirect", bus.redirect, 1);
        tick(); put('0, 1'b0); tick(); put('0, 1'b0);
        chk("jal_wb", {bus.wb_link, bus.wb_regwrite, bus.wb_dst}, {1'b1, 1'b1, 5'd31});
        drain();

        // jr
        put(mk_jr(5'd31), 1'b0); tick();
        put('0, 1'b0);
        chk("jr_redirect", {bus.redirect, bus.ex_jumpr}, 2'b11);
        tick(); drain();

        // forced lu + redirect: redirect wins, no stall
        r = mk_lw(5'd7, 5'd1); r.jump = 1'b1;
        put(r, 1'b0); tick();
        put(mk_r(5'd12, 5'd7, 5'd0), 1'b0);
        chk("lu_redir", {bus.redirect, bus.pc_stall}, 2'b10);
        tick(); put('0, 1'b0);
        chk("lu_redir_bubble", bus.ex_dst, 0);
        drain();

        // back-to-back loads, each with a user, stall independently
        stalls = 0;
        put(mk_lw(5'd5, 5'd1), 1'b0); if (bus.pc_stall) stalls++; tick();
        put(mk_r(5'd13, 5'd5, 5'd0), 1'b0); if (bus.pc_stall) stalls++; tick();
        put(mk_r(5'd13, 5'd5, 5'd0), 1'b0); if (bus.pc_stall) stalls++; tick();
        put(mk_lw(5'd6, 5'd1), 1'b0); if (bus.pc_stall) stalls++; tick();
        put(mk_r(5'd14, 5'd0, 5'd6), 1'b0); if (bus.pc_stall) stalls++; tick();
        put(mk_r(5'd14, 5'd0, 5'd6), 1'b0); if (bus.pc_stall) stalls++; tick();
        put('0, 1'b0); if (bus.pc_stall) stalls++;
        chk("b2b_stalls", stalls, 2);
        drain();

        // reset in the middle of a stall clears everything
        put(mk_lw(5'd5, 5'd1), 1'b0); tick();
        put(mk_r(5'd6, 5'd5, 5'd5), 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        put(mk_r(5'd6, 5'd5, 5'd5), 1'b0);
        chk("rst_mid_stall", {bus.pc_stall, bus.ex_dst, bus.mem_dst, bus.mem_memread},
            0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
